// File: rtl/tmds_seq_pkg.sv
// Shared types and defaults for the TMDS clock-tree power-up sequencer.
package tmds_seq_pkg;

  // Sequencer states, in bring-up order; StFault is off the main path.
  typedef enum logic [2:0] {
    StIdle,
    StPllRst,
    StWaitLock,
    StStable,
    StRelDiv,
    StRelSer,
    StRun,
    StFault
  } seq_state_e;

  localparam int unsigned DefPllRstCycles    = 32;
  localparam int unsigned DefLockTimeoutCyc  = 65536;
  localparam int unsigned DefLockStableCyc   = 1024;
  localparam int unsigned DefStageGapCycles  = 16;
  localparam int unsigned DefMaxRetries      = 3;

  localparam int unsigned RetryW = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the board clock domain.
module lock_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous level through two flops; both clear on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/tmds_clk_sequencer.sv
// Power-up and recovery sequencer for the DVI TX clock tree: drives PLL reset,
// qualifies lock, then releases CLKDIV, serializer and pixel resets in order.
module tmds_clk_sequencer
  import tmds_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCyc,
  parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCyc,
  parameter int unsigned STAGE_GAP_CYCLES    = DefStageGapCycles,
  parameter int unsigned MAX_RETRIES         = DefMaxRetries
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              enable,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic              clkdiv_reset,
  output logic              serdes_reset,
  output logic              pix_reset,
  output logic              ready,
  output logic              fault,
  output logic              lock_lost,
  output logic [RetryW-1:0] retry_count
);

  localparam int unsigned MaxCycles = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                            max_u(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES));
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  typedef logic [CntW-1:0] cnt_t;

  // Terminal counts: the counter reads N-1 on the cycle before the Nth edge in a state.
  localparam cnt_t PllRstLast  = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t TimeoutLast = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t StableLast  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t GapLast     = cnt_t'(STAGE_GAP_CYCLES - 1);
  localparam cnt_t CntMax      = '1;

  localparam logic [RetryW-1:0] RetrySat   = '1;
  localparam logic [RetryW-1:0] RetryLimit = RetryW'(MAX_RETRIES);

  logic              lock_s;
  seq_state_e        state_q, state_d;
  cnt_t              cnt_q;
  logic [RetryW-1:0] retry_d, retry_inc;
  logic              lost_d;

  lock_sync u_lock_sync (
    .clk_i   (clkin),
    .reset_i (reset),
    .async_i (pll_lock),
    .sync_o  (lock_s)
  );

  assign retry_inc = (retry_count == RetrySat) ? retry_count : retry_count + RetryW'(1);

  // Next-state, retry and lock-loss decisions; disable overrides everything.
  always_comb begin
    state_d = state_q;
    retry_d = retry_count;
    lost_d  = 1'b0;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     state_d = StPllRst;
        StPllRst:   if (cnt_q == PllRstLast) state_d = StWaitLock;
        StWaitLock: begin
          // Lock beats a coincident timeout.
          if (lock_s) begin
            state_d = StStable;
          end else if (cnt_q == TimeoutLast) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RetryLimit) ? StFault : StPllRst;
          end
        end
        StStable: begin
          // A drop beats a coincident stable-count completion.
          if (!lock_s)                  state_d = StWaitLock;
          else if (cnt_q == StableLast) state_d = StRelDiv;
        end
        StRelDiv, StRelSer, StRun: begin
          if (!lock_s) begin
            state_d = StPllRst;
            lost_d  = 1'b1;
          end else if (state_q != StRun && cnt_q == GapLast) begin
            state_d = (state_q == StRelDiv) ? StRelSer : StRun;
          end
        end
        StFault:    state_d = StFault;
        default:    state_d = StIdle;
      endcase
    end
    if (state_d inside {StIdle, StRun}) retry_d = '0;
  end

  // State, per-state counter and outputs decoded from the next state.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      retry_count  <= '0;
      pll_reset    <= 1'b1;
      clkdiv_reset <= 1'b1;
      serdes_reset <= 1'b1;
      pix_reset    <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + cnt_t'(1);
      end
      retry_count  <= retry_d;
      pll_reset    <= state_d inside {StIdle, StPllRst, StFault};
      clkdiv_reset <= !(state_d inside {StRelDiv, StRelSer, StRun});
      serdes_reset <= !(state_d inside {StRelSer, StRun});
      pix_reset    <= (state_d != StRun);
      ready        <= (state_d == StRun);
      fault        <= (state_d == StFault);
      lock_lost    <= lost_d;
    end
  end

endmodule

// File: tb/tb_tmds_clk_sequencer.sv
// Bench for tmds_clk_sequencer: constant-expectation vector table, hand-built
// corner sequences, and a randomized run against a timestamp-based reference model.
module tb_tmds_clk_sequencer;

  localparam int PR = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int GP = 3;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       rst, en, lk;
  logic       pll_reset, clkdiv_reset, serdes_reset, pix_reset, ready, fault, lock_lost;
  logic [3:0] retry_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmds_clk_sequencer #(
    .PLL_RST_CYCLES      (PR),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (ST),
    .STAGE_GAP_CYCLES    (GP),
    .MAX_RETRIES         (MR)
  ) dut (
    .clkin        (clk),
    .reset        (rst),
    .enable       (en),
    .pll_lock     (lk),
    .pll_reset    (pll_reset),
    .clkdiv_reset (clkdiv_reset),
    .serdes_reset (serdes_reset),
    .pix_reset    (pix_reset),
    .ready        (ready),
    .fault        (fault),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n active edges and land on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: phases along the bring-up path, timed by the edge at which
  // each phase was entered; lock seen through a two-edge delay line.
  localparam int M_OFF = 0, M_RST = 1, M_WAIT = 2, M_QUAL = 3;
  localparam int M_DIV = 4, M_SER = 5, M_RUN = 6, M_FLT = 7;

  int m_ph  = M_OFF;
  int m_t0  = 0;
  int m_cyc = 0;
  int m_try = 0;
  bit m_lost = 1'b0;
  bit m_dly[2] = '{1'b0, 1'b0};
  bit model_on = 1'b0;

  // Step the model on every active edge from the same inputs the DUT sees.
  always @(posedge clk) begin : ref_model
    int nxt;
    bit ls;
    m_cyc++;
    ls       = m_dly[1];
    m_dly[1] = m_dly[0];
    m_dly[0] = lk;
    m_lost   = 1'b0;
    nxt      = m_ph;
    if (rst) begin
      nxt   = M_OFF;
      m_try = 0;
      m_dly = '{1'b0, 1'b0};
    end else if (!en) begin
      nxt = M_OFF;
    end else begin
      case (m_ph)
        M_OFF:  nxt = M_RST;
        M_RST:  if (m_cyc - m_t0 >= PR) nxt = M_WAIT;
        M_WAIT: begin
          if (ls) nxt = M_QUAL;
          else if (m_cyc - m_t0 >= TO) begin
            m_try = (m_try < 15) ? m_try + 1 : 15;
            nxt   = (m_try == MR) ? M_FLT : M_RST;
          end
        end
        M_QUAL: begin
          if (!ls) nxt = M_WAIT;
          else if (m_cyc - m_t0 >= ST) nxt = M_DIV;
        end
        M_DIV, M_SER, M_RUN: begin
          if (!ls) begin
            nxt    = M_RST;
            m_lost = 1'b1;
          end else if (m_ph != M_RUN && m_cyc - m_t0 >= GP) begin
            nxt = m_ph + 1;
          end
        end
        default: ;
      endcase
    end
    if (nxt != m_ph || rst) m_t0 = m_cyc;
    if (nxt == M_OFF || nxt == M_RUN) m_try = 0;
    m_ph = nxt;
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("model_pll_reset", pll_reset, (m_ph == M_OFF || m_ph == M_RST || m_ph == M_FLT));
      chk("model_clkdiv_reset", clkdiv_reset, !(m_ph >= M_DIV && m_ph <= M_RUN));
      chk("model_serdes_reset", serdes_reset, !(m_ph == M_SER || m_ph == M_RUN));
      chk("model_pix_reset", pix_reset, (m_ph != M_RUN));
      chk("model_ready", ready, (m_ph == M_RUN));
      chk("model_fault", fault, (m_ph == M_FLT));
      chk("model_lock_lost", lock_lost, m_lost);
      chk("model_retry_count", retry_count, m_try);
    end
  end

  typedef struct {
    bit en;
    bit lk;
    int n;
    bit pll;
    bit div;
    bit ser;
    bit pix;
    bit rdy;
    bit flt;
    int rc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk_all(input string tag, input int pll, input int div, input int ser,
                         input int pix, input int rdy, input int flt, input int lost,
                         input int rc);
    chk({tag, "_pll_reset"}, pll_reset, pll);
    chk({tag, "_clkdiv_reset"}, clkdiv_reset, div);
    chk({tag, "_serdes_reset"}, serdes_reset, ser);
    chk({tag, "_pix_reset"}, pix_reset, pix);
    chk({tag, "_ready"}, ready, rdy);
    chk({tag, "_fault"}, fault, flt);
    chk({tag, "_lock_lost"}, lock_lost, lost);
    chk({tag, "_retry_count"}, retry_count, rc);
  endtask

  initial begin
    int seg;
    // Clean bring-up: lock rises 10 cycles after pll_reset falls.
    tbl.push_back('{1, 0, 1,  1, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 3,  1, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 1,  0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 9,  0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 10, 0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 1,  0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 2,  0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 1,  0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 2,  0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 1,  0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 20, 0, 0, 0, 0, 1, 0, 0});
    // Timeouts to fault with lock held low.
    tbl.push_back('{0, 0, 1,  1, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 1,  1, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 4,  0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 19, 0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 1,  1, 1, 1, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 3,  1, 1, 1, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 1,  0, 1, 1, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 20, 1, 1, 1, 1, 0, 0, 2});
    tbl.push_back('{1, 0, 4,  0, 1, 1, 1, 0, 0, 2});
    tbl.push_back('{1, 0, 19, 0, 1, 1, 1, 0, 0, 2});
    tbl.push_back('{1, 0, 1,  1, 1, 1, 1, 0, 1, 3});
    tbl.push_back('{1, 0, 10, 1, 1, 1, 1, 0, 1, 3});
    // Fault recovery.
    tbl.push_back('{0, 0, 1,  1, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 1,  1, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 4,  0, 1, 1, 1, 0, 0, 0});

    rst = 1'b1;
    en  = 1'b0;
    lk  = 1'b0;
    tick(2);
    model_on = 1'b1;
    chk_all("reset", 1, 1, 1, 1, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1);

    foreach (tbl[i]) begin
      en = tbl[i].en;
      lk = tbl[i].lk;
      tick(tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].pll, tbl[i].div, tbl[i].ser, tbl[i].pix,
              tbl[i].rdy, tbl[i].flt, 0, tbl[i].rc);
    end

    // Lock glitch at stable count 5: release must wait for 8 fresh lock cycles.
    en = 1'b0;
    lk = 1'b1;
    tick(3);
    en = 1'b1;
    tick(9);
    lk = 1'b0;
    tick(1);
    lk = 1'b1;
    tick(2);
    tick(8);
    chk("glitch_clkdiv_held", clkdiv_reset, 1);
    tick(1);
    chk("glitch_clkdiv_released", clkdiv_reset, 0);
    tick(6);
    chk("glitch_ready", ready, 1);

    // Lock loss in RUN.
    lk = 1'b0;
    tick(2);
    chk_all("pre_loss", 0, 0, 0, 0, 1, 0, 0, 0);
    tick(1);
    chk_all("loss_edge", 1, 1, 1, 1, 0, 0, 1, 0);
    lk = 1'b1;
    tick(1);
    chk("loss_pulse_end", lock_lost, 0);
    tick(17);
    chk("relock_not_yet", ready, 0);
    tick(1);
    chk("relock_ready", ready, 1);

    // Synchronous reset while in REL_SER.
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(18);
    chk_all("in_rel_ser", 0, 0, 0, 1, 0, 0, 0, 0);
    rst = 1'b1;
    tick(1);
    chk_all("mid_reset", 1, 1, 1, 1, 0, 0, 0, 0);
    rst = 1'b0;
    tick(4);
    chk("post_reset_pll_held", pll_reset, 1);
    tick(1);
    chk("post_reset_pll_rel", pll_reset, 0);

    // Randomized lock segments with rare enable drops and resets.
    seg = 0;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        lk  = ~lk;
        seg = lk ? int'($urandom_range(1, 70)) : int'($urandom_range(1, 45));
      end
      seg--;
      en  = ($urandom_range(0, 299) != 0);
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
